axi4lite_bank_if: RTL and testbench

- Next-generation AXI4-Lite slave to IP-memory bridge. Fans one AXI4-Lite port out to NUM_BANKS independent IP memory banks.
- Adds four behaviours to the single-bank bridge: byte-strobe accumulation across data folds, address-range checking with SLVERR, a read-timeout watchdog, and per-bank read acknowledge.
- Sits between the host control interconnect and weight/parameter memories, e.g. multiple memstream instances.

---
 rtl/axi4lite_bank_if.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi4lite_bank_if.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_bank_if.sv
`default_nettype none
// axi4lite_bank_if - AXI4-Lite slave fanning one port out to NUM_BANKS IP memory banks.
// Rev 1.0 - fold strobe accumulation, range check with SLVERR, read watchdog, per-bank read ack.
module axi4lite_bank_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int IP_DATA_WIDTH  = 64,
  parameter int NUM_BANKS      = 4,
  parameter int BANK_ADDR_BITS = 12,
  parameter int RD_TIMEOUT     = 16
) (
  input  logic                                              aclk,
  input  logic                                              aresetn,
  input  logic                                              i_awvalid,
  output logic                                              o_awready,
  input  logic [ADDR_WIDTH-1:0]                             i_awaddr,
  input  logic [2:0]                                        i_awprot,
  input  logic                                              i_wvalid,
  output logic                                              o_wready,
  input  logic [DATA_WIDTH-1:0]                             i_wdata,
  input  logic [DATA_WIDTH/8-1:0]                           i_wstrb,
  output logic                                              o_bvalid,
  input  logic                                              i_bready,
  output logic [1:0]                                        o_bresp,
  input  logic                                              i_arvalid,
  output logic                                              o_arready,
  input  logic [ADDR_WIDTH-1:0]                             i_araddr,
  input  logic [2:0]                                        i_arprot,
  output logic                                              o_rvalid,
  input  logic                                              i_rready,
  output logic [DATA_WIDTH-1:0]                             o_rdata,
  output logic [1:0]                                        o_rresp,
  output logic [NUM_BANKS-1:0]                              o_ip_en,
  output logic                                              o_ip_wen,
  output logic [BANK_ADDR_BITS-$clog2(IP_DATA_WIDTH/8)-1:0] o_ip_addr,
  output logic [IP_DATA_WIDTH-1:0]                          o_ip_wdata,
  output logic [IP_DATA_WIDTH/8-1:0]                        o_ip_wstrb,
  input  logic [NUM_BANKS-1:0]                              i_ip_rack,
  input  logic [NUM_BANKS*IP_DATA_WIDTH-1:0]                i_ip_rdata
);

  localparam int c_nf    = IP_DATA_WIDTH / DATA_WIDTH;
  localparam int c_sw    = DATA_WIDTH / 8;
  localparam int c_isw   = IP_DATA_WIDTH / 8;
  localparam int c_alsb  = $clog2(c_sw);
  localparam int c_iplsb = $clog2(c_isw);
  localparam int c_ipaw  = BANK_ADDR_BITS - c_iplsb;
  localparam int c_fw    = (c_nf > 1) ? $clog2(c_nf) : 1;
  localparam int c_bw    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int c_cw    = $clog2(RD_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] c_limit = (ADDR_WIDTH+1)'(NUM_BANKS) << BANK_ADDR_BITS;
  localparam logic [1:0] c_okay   = 2'b00;
  localparam logic [1:0] c_slverr = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_t;

  state_t                             r_state, w_state_nxt;
  logic                               r_awready, r_wready, r_arready;
  logic                               r_bvalid, r_rvalid;
  logic [1:0]                         r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]              r_rdata;
  logic [NUM_BANKS-1:0]               r_ip_en;
  logic                               r_ip_wen;
  logic [c_ipaw-1:0]                  r_ip_addr;
  logic [IP_DATA_WIDTH-1:0]           r_ip_wdata;
  logic [c_isw-1:0]                   r_ip_wstrb;
  logic [c_nf-1:0][DATA_WIDTH-1:0]    r_stage, w_stage_mrg;
  logic [c_nf-1:0][c_sw-1:0]          r_strb, w_strb_mrg;
  logic [c_bw-1:0]                    r_bank;
  logic [c_fw-1:0]                    r_fold;
  logic [c_cw-1:0]                    r_cnt;

  logic                               w_aw_fire, w_ar_fire, w_in_range, w_last;
  logic [ADDR_WIDTH-1:0]              w_addr;
  logic [c_fw-1:0]                    w_fold;
  logic [c_bw-1:0]                    w_bank;
  logic [NUM_BANKS-1:0]               w_bank_oh;
  logic [c_ipaw-1:0]                  w_ip_addr;
  logic [IP_DATA_WIDTH-1:0]           w_rslice, w_rshift;
  logic                               w_rack, w_timeout;
  logic                               w_unused_prot;

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $error("axi4lite_bank_if: DATA_WIDTH must be 32 or 64");
    end
  endgenerate

  // Write wins over a simultaneous read, so the decode follows the write address then.
  assign w_aw_fire  = (r_state == IDLE) && i_awvalid && i_wvalid;
  assign w_ar_fire  = (r_state == IDLE) && i_arvalid && !(i_awvalid && i_wvalid);
  assign w_addr     = (i_awvalid && i_wvalid) ? i_awaddr : i_araddr;
  assign w_in_range = {1'b0, w_addr} < c_limit;
  assign w_ip_addr  = w_addr[BANK_ADDR_BITS-1:c_iplsb];
  assign w_bank_oh  = NUM_BANKS'(1) << w_bank;
  assign w_last     = (w_fold == c_fw'(c_nf - 1));

  generate
    if (c_nf > 1) begin : g_fold
      assign w_fold = w_addr[c_alsb +: c_fw];
    end else begin : g_single_fold
      assign w_fold = '0;
    end
    if (NUM_BANKS > 1) begin : g_bank
      assign w_bank = w_addr[BANK_ADDR_BITS +: c_bw];
    end else begin : g_single_bank
      assign w_bank = '0;
    end
  endgenerate

  always_comb begin
    w_stage_mrg         = r_stage;
    w_strb_mrg          = r_strb;
    w_stage_mrg[w_fold] = i_wdata;
    w_strb_mrg[w_fold]  = i_wstrb;
  end

  assign w_rslice      = i_ip_rdata[32'(r_bank) * IP_DATA_WIDTH +: IP_DATA_WIDTH];
  assign w_rshift      = w_rslice >> (32'(r_fold) * DATA_WIDTH);
  assign w_rack        = i_ip_rack[r_bank];
  assign w_timeout     = (r_cnt == c_cw'(RD_TIMEOUT - 1));
  assign w_unused_prot = ^{i_awprot, i_arprot};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_aw_fire)      w_state_nxt = WR_RESP;
        else if (w_ar_fire) w_state_nxt = w_in_range ? RD_WAIT : RD_RESP;
      end
      WR_RESP: if (r_bvalid && i_bready)    w_state_nxt = IDLE;
      RD_WAIT: if (w_rack || w_timeout)     w_state_nxt = RD_RESP;
      RD_RESP: if (r_rvalid && i_rready)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_arready  <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= c_okay;
      r_rvalid   <= 1'b0;
      r_rresp    <= c_okay;
      r_rdata    <= '0;
      r_ip_en    <= '0;
      r_ip_wen   <= 1'b0;
      r_ip_addr  <= '0;
      r_ip_wdata <= '0;
      r_ip_wstrb <= '0;
      r_stage    <= '0;
      r_strb     <= '0;
      r_bank     <= '0;
      r_fold     <= '0;
      r_cnt      <= '0;
    end else begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_ip_en   <= '0;
      r_ip_wen  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_aw_fire) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bresp   <= w_in_range ? c_okay : c_slverr;
            if (w_in_range) begin
              r_stage[w_fold] <= i_wdata;
              r_strb[w_fold]  <= i_wstrb;
              // Last fold completes the IP word; staged strobes restart for the next word.
              if (w_last) begin
                r_ip_en    <= w_bank_oh;
                r_ip_wen   <= 1'b1;
                r_ip_addr  <= w_ip_addr;
                r_ip_wdata <= w_stage_mrg;
                r_ip_wstrb <= w_strb_mrg;
                r_strb     <= '0;
              end
            end
          end else if (w_ar_fire) begin
            r_arready <= 1'b1;
            r_cnt     <= '0;
            r_bank    <= w_bank;
            r_fold    <= w_fold;
            r_rdata   <= '0;
            r_rresp   <= w_in_range ? c_okay : c_slverr;
            if (w_in_range) begin
              r_ip_en   <= w_bank_oh;
              r_ip_addr <= w_ip_addr;
            end
          end
        end
        WR_RESP: begin
          if (!r_bvalid) begin
            r_bvalid <= 1'b1;
          end else if (i_bready) begin
            r_bvalid <= 1'b0;
            r_bresp  <= c_okay;
          end
        end
        RD_WAIT: begin
          if (w_rack) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rshift[DATA_WIDTH-1:0];
            r_rresp  <= c_okay;
          end else if (w_timeout) begin
            r_rvalid <= 1'b1;
            r_rdata  <= '0;
            r_rresp  <= c_slverr;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        RD_RESP: begin
          // Out-of-range reads arrive here without rvalid and raise it one cycle later.
          if (!r_rvalid) begin
            r_rvalid <= 1'b1;
          end else if (i_rready) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_okay;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_awready  = r_awready;
  assign o_wready   = r_wready;
  assign o_arready  = r_arready;
  assign o_bvalid   = r_bvalid;
  assign o_bresp    = r_bresp;
  assign o_rvalid   = r_rvalid;
  assign o_rresp    = r_rresp;
  assign o_rdata    = r_rdata;
  assign o_ip_en    = r_ip_en;
  assign o_ip_wen   = r_ip_wen;
  assign o_ip_addr  = r_ip_addr;
  assign o_ip_wdata = r_ip_wdata;
  assign o_ip_wstrb = r_ip_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_bank_if.sv
`default_nettype none
// tb_axi4lite_bank_if - directed plan steps followed by random traffic checked against a
// lane/strobe reference model of the bridge.
module tb_axi4lite_bank_if;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IPW = 64;
  localparam int NB  = 4;
  localparam int BAB = 12;
  localparam int TO  = 16;
  localparam int NF  = IPW / DW;
  localparam int SB  = DW / 8;
  localparam int ISB = IPW / 8;
  localparam int IPA = BAB - $clog2(ISB);

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              i_awvalid = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
  logic              i_arvalid = 1'b0, i_rready = 1'b0;
  logic [AW-1:0]     i_awaddr = '0, i_araddr = '0;
  logic [2:0]        i_awprot = '0, i_arprot = '0;
  logic [DW-1:0]     i_wdata = '0;
  logic [SB-1:0]     i_wstrb = '0;
  logic [NB-1:0]     i_ip_rack = '0;
  logic [NB*IPW-1:0] i_ip_rdata = '0;
  logic              o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_ip_wen;
  logic [1:0]        o_bresp, o_rresp;
  logic [DW-1:0]     o_rdata;
  logic [NB-1:0]     o_ip_en;
  logic [IPA-1:0]    o_ip_addr;
  logic [IPW-1:0]    o_ip_wdata;
  logic [ISB-1:0]    o_ip_wstrb;

  always #5 aclk = ~aclk;

  axi4lite_bank_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IP_DATA_WIDTH(IPW),
    .NUM_BANKS(NB), .BANK_ADDR_BITS(BAB), .RD_TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awprot(i_awprot),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arprot(i_arprot),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_ip_en(o_ip_en), .o_ip_wen(o_ip_wen), .o_ip_addr(o_ip_addr),
    .o_ip_wdata(o_ip_wdata), .o_ip_wstrb(o_ip_wstrb),
    .i_ip_rack(i_ip_rack), .i_ip_rdata(i_ip_rdata)
  );

  typedef struct {
    logic [NB-1:0]  en;
    logic           wen;
    logic [IPA-1:0] addr;
    logic [IPW-1:0] wdata;
    logic [ISB-1:0] wstrb;
  } ip_ev_t;

  ip_ev_t        evq[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] m_lane[NF];
  logic [SB-1:0] m_strb[NF];

  // Every cycle with any bank strobe becomes one recorded IP access.
  always @(negedge aclk) begin
    if (o_ip_en !== '0) evq.push_back('{o_ip_en, o_ip_wen, o_ip_addr, o_ip_wdata, o_ip_wstrb});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NF; l++) begin
      m_lane[l] = '0;
      m_strb[l] = '0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, o_awready, 0);
    chk({tag, "_wready"}, o_wready, 0);
    chk({tag, "_arready"}, o_arready, 0);
    chk({tag, "_bvalid"}, o_bvalid, 0);
    chk({tag, "_bresp"}, o_bresp, 0);
    chk({tag, "_rvalid"}, o_rvalid, 0);
    chk({tag, "_rdata"}, o_rdata, 0);
    chk({tag, "_rresp"}, o_rresp, 0);
    chk({tag, "_ip_en"}, o_ip_en, 0);
    chk({tag, "_ip_wen"}, o_ip_wen, 0);
    chk({tag, "_ip_addr"}, o_ip_addr, 0);
    chk({tag, "_ip_wdata"}, o_ip_wdata, 0);
    chk({tag, "_ip_wstrb"}, o_ip_wstrb, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SB-1:0] strb, input int hold);
    logic           in_rng, exp_ev;
    int             fold, bank;
    logic [IPW-1:0] ew;
    logic [ISB-1:0] es;
    in_rng = (addr < (NB << BAB));
    fold   = int'((addr / SB) % NF);
    bank   = int'(addr >> BAB) % NB;
    exp_ev = 1'b0;
    ew     = '0;
    es     = '0;
    if (in_rng) begin
      m_lane[fold] = data;
      m_strb[fold] = strb;
      if (fold == NF - 1) begin
        exp_ev = 1'b1;
        for (int l = 0; l < NF; l++) begin
          ew[l*DW +: DW] = m_lane[l];
          es[l*SB +: SB] = m_strb[l];
          m_strb[l]      = '0;
        end
      end
    end
    evq.delete();
    @(negedge aclk);
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_awaddr = addr; i_wdata = data; i_wstrb = strb;
    i_bready = 1'b0;
    @(negedge aclk);
    chk("awready", o_awready, 1);
    chk("wready", o_wready, 1);
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    @(negedge aclk);
    chk("awready_pulse", o_awready, 0);
    chk("bvalid", o_bvalid, 1);
    chk("bresp", o_bresp, in_rng ? 2'b00 : 2'b10);
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      chk("bvalid_hold", o_bvalid, 1);
    end
    i_bready = 1'b1;
    @(negedge aclk);
    i_bready = 1'b0;
    chk("bvalid_clr", o_bvalid, 0);
    chk("wr_ip_events", evq.size(), exp_ev);
    if (exp_ev && evq.size() > 0) begin
      chk("wr_ip_en", evq[0].en, 64'd1 << bank);
      chk("wr_ip_wen", evq[0].wen, 1);
      chk("wr_ip_addr", evq[0].addr, (addr % (1 << BAB)) / ISB);
      chk("wr_ip_wdata", evq[0].wdata, ew);
      chk("wr_ip_wstrb", evq[0].wstrb, es);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int ack_d, input int wrong_d,
                         input logic [IPW-1:0] bdata, output logic [DW-1:0] rd);
    logic           in_rng;
    int             fold, bank, c, got, exp_lat;
    logic [IPW-1:0] sh;
    logic [DW-1:0]  exp_rd;
    logic [1:0]     exp_rr, rr;
    in_rng = (addr < (NB << BAB));
    fold   = int'((addr / SB) % NF);
    bank   = int'(addr >> BAB) % NB;
    for (int b = 0; b < NB; b++) i_ip_rdata[b*IPW +: IPW] = {$urandom, $urandom};
    if (in_rng) i_ip_rdata[bank*IPW +: IPW] = bdata;
    sh      = bdata >> (fold * DW);
    exp_rd  = (in_rng && ack_d >= 0) ? sh[DW-1:0] : '0;
    exp_rr  = (in_rng && ack_d >= 0) ? 2'b00 : 2'b10;
    exp_lat = !in_rng ? 2 : ((ack_d >= 0) ? ack_d + 2 : TO + 1);
    evq.delete();
    @(negedge aclk);
    i_arvalid = 1'b1; i_araddr = addr; i_rready = 1'b1;
    got = -1; c = 0; rd = '0; rr = 2'b11;
    while (got < 0 && c < TO + 8) begin
      @(negedge aclk);
      c++;
      i_ip_rack = '0;
      if (c == 1) begin
        chk("arready", o_arready, 1);
        i_arvalid = 1'b0;
      end
      if (o_rvalid) begin
        got = c; rd = o_rdata; rr = o_rresp;
      end else if (in_rng) begin
        if (c == 1 + ack_d)   i_ip_rack[bank] = 1'b1;
        if (c == 1 + wrong_d) i_ip_rack[(bank + 1) % NB] = 1'b1;
      end
    end
    i_ip_rack = '0;
    chk("rd_latency", got, exp_lat);
    chk("rdata", rd, exp_rd);
    chk("rresp", rr, exp_rr);
    @(negedge aclk);
    i_rready = 1'b0;
    chk("rvalid_clr", o_rvalid, 0);
    chk("rdata_clr", o_rdata, 0);
    chk("rd_ip_events", evq.size(), in_rng ? 1 : 0);
    if (in_rng && evq.size() > 0) begin
      chk("rd_ip_en", evq[0].en, 64'd1 << bank);
      chk("rd_ip_wen", evq[0].wen, 0);
      chk("rd_ip_addr", evq[0].addr, (addr % (1 << BAB)) / ISB);
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    model_reset();
    repeat (3) @(negedge aclk);
    chk_all_zero("reset");
    aresetn = 1'b1;

    // Two-fold write accumulating strobes into one IP word.
    do_write(32'h0000_1008, 32'hAAAA_5555, 4'hF, 0);
    do_write(32'h0000_100C, 32'h1234_5678, 4'h3, 0);
    if (evq.size() > 0) begin
      chk("tp_wdata", evq[0].wdata, 64'h1234_5678_AAAA_5555);
      chk("tp_wstrb", evq[0].wstrb, 8'h3F);
      chk("tp_en", evq[0].en, 4'b0010);
      chk("tp_addr", evq[0].addr, 1);
    end

    do_read(32'h0000_2004, 3, -1, 64'hDEAD_BEEF_CAFE_F00D, rd);
    chk("tp_rdata", rd, 32'hDEAD_BEEF);

    do_write(32'h0000_4000, 32'h0BAD_0BAD, 4'hF, 0);
    do_read(32'h0000_4000, 0, -1, 64'h1111_2222_3333_4444, rd);

    // Watchdog expiry with only a foreign-bank ack, then a stray ack while idle.
    do_read(32'h0000_3008, -1, 1, 64'h5555_6666_7777_8888, rd);
    evq.delete();
    @(negedge aclk);
    i_ip_rack = 4'b1000;
    @(negedge aclk);
    i_ip_rack = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("stray_ack_rvalid", o_rvalid, 0);
    end
    chk("stray_ack_ip_events", evq.size(), 0);

    // Simultaneous write and read: write first, bready held low for five cycles.
    m_lane[0] = 32'hC0DE_0001;
    m_strb[0] = 4'h5;
    i_ip_rdata[1*IPW +: IPW] = 64'hFEED_FACE_0123_4567;
    @(negedge aclk);
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
    i_awaddr = 32'h0; i_araddr = 32'h0000_1004; i_wdata = 32'hC0DE_0001; i_wstrb = 4'h5;
    i_bready = 1'b0; i_rready = 1'b1;
    @(negedge aclk);
    chk("sim_awready", o_awready, 1);
    chk("sim_arready_blocked", o_arready, 0);
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("sim_bvalid_hold", o_bvalid, 1);
      chk("sim_arready_wait", o_arready, 0);
    end
    i_bready = 1'b1;
    @(negedge aclk);
    i_bready = 1'b0;
    chk("sim_bvalid_clr", o_bvalid, 0);
    chk("sim_arready_idle", o_arready, 0);
    @(negedge aclk);
    chk("sim_arready", o_arready, 1);
    chk("sim_ip_en", o_ip_en, 4'b0010);
    i_arvalid = 1'b0;
    i_ip_rack = 4'b0010;
    @(negedge aclk);
    i_ip_rack = '0;
    chk("sim_rvalid", o_rvalid, 1);
    chk("sim_rdata", o_rdata, 32'hFEED_FACE);
    @(negedge aclk);
    i_rready = 1'b0;
    chk("sim_rvalid_clr", o_rvalid, 0);

    // Reset during RD_WAIT; staging must also be wiped.
    do_write(32'h0000_0010, 32'h7777_7777, 4'hF, 0);
    @(negedge aclk);
    i_arvalid = 1'b1; i_araddr = 32'h0000_3010; i_rready = 1'b1;
    @(negedge aclk);
    i_arvalid = 1'b0;
    chk("mid_ip_en", o_ip_en, 4'b1000);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    i_ip_rack = 4'b1000;
    @(negedge aclk);
    i_ip_rack = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("mid_late_ack_rvalid", o_rvalid, 0);
    end
    i_rready = 1'b0;
    do_write(32'h0000_0014, 32'h0102_0304, 4'h9, 1);
    do_read(32'h0000_3010, 2, -1, 64'h0A0B_0C0D_0E0F_1011, rd);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h4000 + ($urandom & 32'h0FFF_FFFC);
      else a = ($urandom_range(0, NB - 1) << BAB) | ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, SB'($urandom_range(0, (1 << SB) - 1)), int'($urandom_range(0, 3)));
      else
        do_read(a, ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
                {$urandom, $urandom}, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
